weight_mac: RTL and testbench
=============================

# weight_mac

Weight-consuming 3x3 multiply-accumulate stage that sits directly downstream of the weight ROM. On a start pulse it fetches nine 8-bit weights from the ROM at a programmable base address and multiplies each by one pixel from an upstream valid/ready stream. It then presents the 20-bit sum and an 8-bit shifted, saturated pixel to the next stage through a valid/ready handshake.

## Interface
- `KSIZE`, 9: taps per window.
- `ADDR_W`, 8: ROM address width.
- `DATA_W`, 8: pixel and weight width.
- `ACC_W`, 20: accumulator width; 9 × 255 × 255 fits.
- `SHIFT`, 4: right shift applied before saturation to `res_pix`.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle request to begin a window; honoured only in IDLE.
- `kbase  in  ADDR_W`: kernel base address, latched on an accepted `start`.
- `pix_valid  in  1`: upstream pixel valid.
- `pix_data  in  DATA_W`: upstream pixel, unsigned.
- `pix_ready  out  1`: block accepts a pixel this cycle.
- `rom_en  out  1`: ROM read enable.
- `rom_addr  out  ADDR_W`: ROM address.
- `rom_data  in  DATA_W`: ROM weight, unsigned; combinational from `rom_addr`/`rom_en`, high-Z when `rom_en`=0.
- `res_valid  out  1`: result valid.
- `res_ready  in  1`: downstream accepts the result.
- `res_acc  out  ACC_W`: raw accumulated sum.
- `res_pix  out  DATA_W`: min(`res_acc` >> `SHIFT`, 255).
- `busy  out  1`: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: `start`=1 → latch `kbase`, clear `tap` and `acc` → RUN.
  - RUN: `pix_ready`=1. A beat is `pix_valid & pix_ready`. On each beat, `acc += pix_data * rom_data` and `tap++`. The beat with `tap`=KSIZE-1 → HOLD.
  - HOLD: `res_valid`=1 with `res_acc`/`res_pix` stable. `res_valid & res_ready` → IDLE.
- ROM access:
  - `rom_en` = RUN & `pix_valid`.
  - `rom_addr` = (`kbase_q` + `tap`) mod 2^ADDR_W, so addresses wrap from 255 to 0.
  - When `rom_en`=0, `rom_addr` is driven 0.
  - `rom_data` is sampled only in a cycle where `rom_en`=1; it is never sampled while high-Z.
- Arithmetic:
  - 8×8 unsigned product, 16 bits, zero-extended to ACC_W before the add.
  - No overflow is possible at the default widths.
  - `res_pix` saturates to 255 when any bit of `res_acc` >> SHIFT above bit 7 is set.
- Ignored events:
  - `start` outside IDLE is ignored and not queued; `kbase` changes are likewise ignored.
  - `pix_valid` outside RUN is not accepted (`pix_ready`=0).
- Asynchronous reset at any time, including mid-window: the window is abandoned and no partial result is emitted.

## Timing
- Reset values: state IDLE, `pix_ready`=0, `rom_en`=0, `rom_addr`=0, `res_valid`=0, `res_acc`=0, `res_pix`=0, `busy`=0, internal `tap`=0, `acc`=0.
- `start` sampled at edge N → RUN from cycle N+1. The first beat can occur in cycle N+1.
- With no bubbles, the 9th beat falls in cycle N+9 and `res_valid` rises in cycle N+10. A new `start` is accepted in the cycle after the result handshake, at the earliest.
- Pixel bubbles extend RUN one cycle each; `acc` and `tap` hold during a bubble.
- `res_valid` stays high with stable data until `res_ready`. If `res_ready` is held high, `res_valid` is high for exactly 1 cycle.
- `res_acc`/`res_pix` are registered and update on entry to HOLD. They hold their value afterwards until the next HOLD entry.

## Structure
- Shared package `weight_mac_pkg` contains:
  - state enum {IDLE, RUN, HOLD};
  - KSIZE, ADDR_W, DATA_W, ACC_W, SHIFT defaults;
  - a `sat_shift` function producing `res_pix` from an accumulator.
- One flat module; no sub-module. The datapath (one multiplier and one adder) is too small to split.

## Test plan
- kbase=0x00, nine pixels of 1, no bubbles, `res_ready`=1:
  - `rom_addr` runs 0x00..0x08 on consecutive cycles;
  - `res_acc`=256, `res_pix`=16;
  - `res_valid` high exactly in cycle start+10.
- kbase=18, nine pixels of 0xFF → `res_acc`=16320, `res_pix`=255 (saturated).
- kbase=0, pixels 1, with `pix_valid` low for 3 cycles after tap 4:
  - `rom_en`=0 and `acc` frozen during the gap;
  - result unchanged (256); `res_valid` at start+13.
- Result back-pressure:
  - Hold `res_ready`=0 for 5 cycles → `res_valid` and data stable throughout.
  - Pulse `start` during HOLD → ignored; `busy` stays 1.
  - Release `res_ready` → IDLE next cycle.
- kbase=0xFC → `rom_addr` sequence 0xFC,0xFD,0xFE,0xFF,0x00,0x01,0x02,0x03,0x04.
- Assert `rst_n`=0 after the 5th beat:
  - all outputs go to reset values immediately and no `res_valid` appears;
  - a fresh window with kbase=0 and pixels of 1 then yields 256.

Source files
------------

// File: rtl/weight_mac_pkg.sv
// rtl/weight_mac_pkg.sv - shared widths, state encoding and result saturation for weight_mac
package weight_mac_pkg;

  localparam int KSIZE  = 9;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int SHIFT  = 4;
  localparam int TAP_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Shift the sum down and clamp anything that no longer fits in a pixel.
  function automatic logic [DATA_W-1:0] sat_shift(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] shifted;
    shifted = acc >> SHIFT;
    if (|shifted[ACC_W-1:DATA_W]) begin
      sat_shift = {DATA_W{1'b1}};
    end else begin
      sat_shift = shifted[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/weight_mac.sv
// rtl/weight_mac.sv - 3x3 weight-ROM driven multiply-accumulate with valid/ready result
module weight_mac
  import weight_mac_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_kbase,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_pix_ready,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [ACC_W-1:0]  o_res_acc,
  output logic [DATA_W-1:0] o_res_pix,
  output logic              o_busy
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_kbase;
  logic [TAP_W-1:0]    r_tap;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_res_acc;
  logic [DATA_W-1:0]   r_res_pix;

  logic                w_run;
  logic                w_beat;
  logic                w_last;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_acc_next;

  // Weight reads only happen on a real beat so the ROM bus is never sampled while floating.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_beat     = w_run & i_pix_valid;
    w_last     = (r_tap == TAP_W'(KSIZE - 1));
    w_prod     = '0;
    w_acc_next = r_acc;
    if (w_beat) begin
      w_prod     = i_pix_data * i_rom_data;
      w_acc_next = r_acc + ACC_W'(w_prod);
    end
  end

  // Control: start in IDLE, count beats in RUN, wait for the downstream handshake in HOLD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_kbase <= '0;
      r_tap   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_kbase <= i_kbase;
            r_tap   <= '0;
            r_acc   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            r_tap <= r_tap + 1'b1;
            if (w_last) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (i_res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result registers capture the final sum on HOLD entry and keep it until the next window ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_acc <= '0;
      r_res_pix <= '0;
    end else if (w_beat && w_last) begin
      r_res_acc <= w_acc_next;
      r_res_pix <= sat_shift(w_acc_next);
    end
  end

  // Output decode; the address is parked at zero whenever the ROM is not enabled.
  always_comb begin
    o_pix_ready = w_run;
    o_rom_en    = w_beat;
    o_rom_addr  = w_beat ? (r_kbase + ADDR_W'(r_tap)) : '0;
    o_res_valid = (r_state == ST_HOLD);
    o_res_acc   = r_res_acc;
    o_res_pix   = r_res_pix;
    o_busy      = (r_state != ST_IDLE);
  end

endmodule

// File: tb/tb_weight_mac.sv
// tb/tb_weight_mac.sv - scoreboard bench for weight_mac
module tb_weight_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  kbase;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        rom_en;
  logic [7:0]  rom_addr;
  wire  [7:0]  rom_data;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_acc;
  logic [7:0]  res_pix;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  addr_q[$];
  logic [27:0] res_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  // ROM: a 3x3 kernel summing to 256 at 0, one summing to 64 at 18, a ramp elsewhere.
  function automatic logic [7:0] rom_w(input logic [7:0] a);
    logic [7:0] k0 [9] = '{8'd16, 8'd32, 8'd16, 8'd32, 8'd64, 8'd32, 8'd16, 8'd32, 8'd16};
    logic [7:0] k1 [9] = '{8'd4, 8'd8, 8'd4, 8'd8, 8'd16, 8'd8, 8'd4, 8'd8, 8'd4};
    logic [15:0] r;
    if (a < 8'd9) return k0[a];
    if (a >= 8'd18 && a < 8'd27) return k1[a - 8'd18];
    r = 16'(a) * 16'd7 + 16'd3;
    return r[7:0];
  endfunction

  assign rom_data = rom_en ? rom_w(rom_addr) : 8'hzz;

  weight_mac dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_kbase    (kbase),
    .i_pix_valid(pix_valid),
    .i_pix_data (pix_data),
    .o_pix_ready(pix_ready),
    .o_rom_en   (rom_en),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_res_valid(res_valid),
    .i_res_ready(res_ready),
    .o_res_acc  (res_acc),
    .o_res_pix  (res_pix),
    .o_busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops addresses, latencies and results as the DUT presents them.
  int          ncnt = 0;
  int          start_cnt = 0;
  logic        p_busy = 1'b0, p_valid = 1'b0, p_ready = 1'b0;
  logic [19:0] p_acc = '0;
  logic [7:0]  p_pix = '0;

  always @(negedge clk) begin
    ncnt++;
    if (!rst_n) begin
      p_busy  = 1'b0;
      p_valid = 1'b0;
      p_ready = 1'b0;
    end else begin
      if (rom_en) begin
        if (addr_q.size() == 0) chk("rom_en_unexpected", 32'(rom_addr), 32'hFFFF);
        else chk("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
      end else begin
        chk("rom_addr_idle", 32'(rom_addr), 32'h0);
      end
      if (busy && !p_busy) start_cnt = ncnt;
      if (res_valid && !p_valid) begin
        if (lat_q.size() != 0) chk("latency", 32'(ncnt - start_cnt), 32'(lat_q.pop_front()));
      end
      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(res_valid), 32'h1);
        chk("hold_acc", 32'(res_acc), 32'(p_acc));
        chk("hold_pix", 32'(res_pix), 32'(p_pix));
      end
      if (p_valid && p_ready) begin
        chk("valid_drop", 32'(res_valid), 32'h0);
        chk("idle_after_hs", 32'(busy), 32'h0);
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          chk("result_unexpected", 32'(res_acc), 32'hFFFFF);
        end else begin
          logic [27:0] e;
          e = res_q.pop_front();
          chk("res_acc", 32'(res_acc), 32'(e[27:8]));
          chk("res_pix", 32'(res_pix), 32'(e[7:0]));
        end
      end
      p_busy  = busy;
      p_valid = res_valid;
      p_ready = res_ready;
      p_acc   = res_acc;
      p_pix   = res_pix;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start, then nine beats of pixel p with an optional bubble before beat gap_at.
  task automatic do_window(input logic [7:0] kb, input logic [7:0] p, input int gap_at,
                           input int gap_len, input int nbeats, input logic [19:0] e_acc,
                           input logic [7:0] e_pix, input int e_lat, input bit expect_res);
    for (int i = 0; i < nbeats; i++) addr_q.push_back(kb + 8'(i));
    if (expect_res) begin
      res_q.push_back({e_acc, e_pix});
      lat_q.push_back(e_lat);
    end
    start = 1'b1;
    kbase = kb;
    tick();
    start = 1'b0;
    kbase = 8'h5A;
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at) begin
        pix_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) tick();
      end
      pix_valid = 1'b1;
      pix_data  = p;
      tick();
    end
    pix_valid = 1'b0;
    pix_data  = 8'hEE;
  endtask

  task automatic wait_hs();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (res_valid && res_ready) seen = 1'b1;
    end
    if (!seen) chk("handshake_timeout", 32'h0, 32'h1);
    tick();
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    kbase     = 8'h00;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    res_ready = 1'b1;
    tick();
    tick();
    chk("rst_pix_ready", 32'(pix_ready), 32'h0);
    chk("rst_rom_en", 32'(rom_en), 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_acc", 32'(res_acc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // pixels ignored outside RUN
    pix_valid = 1'b1;
    #1 chk("idle_pix_ready", 32'(pix_ready), 32'h0);
    pix_valid = 1'b0;
    tick();

    // basic window: 256 -> 16, result at start+10
    do_window(8'h00, 8'd1, -1, 0, 9, 20'd256, 8'd16, 9, 1'b1);
    wait_hs();

    // saturating window
    do_window(8'd18, 8'hFF, -1, 0, 9, 20'd16320, 8'd255, 9, 1'b1);
    wait_hs();

    // three-cycle bubble after tap 4
    do_window(8'h00, 8'd1, 5, 3, 9, 20'd256, 8'd16, 12, 1'b1);
    wait_hs();

    // address wrap 0xFC..0x04, pixels of 2: 2*1126 = 2252 -> 140
    do_window(8'hFC, 8'd2, -1, 0, 9, 20'd2252, 8'd140, 9, 1'b1);
    wait_hs();

    // back-pressure with an ignored start during HOLD
    res_ready = 1'b0;
    do_window(8'h00, 8'd1, -1, 0, 9, 20'd256, 8'd16, 9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1;
        kbase = 8'h33;
      end
      tick();
      start = 1'b0;
    end
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_res_valid", 32'(res_valid), 32'h1);
    res_ready = 1'b1;
    wait_hs();
    chk("no_queued_start", 32'(busy), 32'h0);

    // reset after the fifth beat abandons the window
    do_window(8'h00, 8'd1, -1, 0, 5, 20'd0, 8'd0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pix_ready", 32'(pix_ready), 32'h0);
    chk("mid_rst_rom_en", 32'(rom_en), 32'h0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'h0);
    chk("mid_rst_res_acc", 32'(res_acc), 32'h0);
    chk("mid_rst_res_pix", 32'(res_pix), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_window(8'h00, 8'd1, -1, 0, 9, 20'd256, 8'd16, 9, 1'b1);
    wait_hs();

    chk("res_q_empty", 32'(res_q.size()), 32'h0);
    chk("addr_q_empty", 32'(addr_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
